// File: rtl/fifo_rdpack.sv
// fifo_rdpack: drains an asynchronous-read FIFO and packs NW words into one wide
// valid/ready beat. A flush pushes out a partial beat tagged with o_last.
module fifo_rdpack #(
    parameter int   BW            = 8,
    parameter int   NW            = 4,
    parameter logic OPT_MSB_FIRST = 1'b0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    output logic                      o_rd,
    input  logic                      i_empty,
    input  logic [BW-1:0]             i_data,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [BW*NW-1:0]          o_data,
    output logic [$clog2(NW):0]       o_count,
    output logic                      o_last,
    output logic                      o_busy
);
    localparam int LGNW = $clog2(NW);
    localparam int CW   = LGNW + 1;
    localparam int W    = BW * NW;
    localparam logic [LGNW-1:0] LAST_LANE = LGNW'(NW - 1);

    logic [W-1:0]    acc_q, acc_d, acc_ins;
    logic [LGNW-1:0] cnt_q, cnt_d, lane;
    logic            flush_pend_q, flush_pend_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    data_q, data_d;
    logic [CW-1:0]   count_q, count_d;
    logic            last_q, last_d;
    logic            out_free, rd;

    always_comb begin
        out_free = !valid_q || i_ready;
        // The pop completing a beat needs the output register free to land in.
        rd = !i_reset && !i_empty && !flush_pend_q &&
             ((cnt_q != LAST_LANE) || out_free);
        lane = OPT_MSB_FIRST ? (LAST_LANE - cnt_q) : cnt_q;

        acc_ins = acc_q;
        for (int i = 0; i < NW; i++) begin
            if (lane == LGNW'(i)) acc_ins[i*BW +: BW] = i_data;
        end

        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q && !i_ready;
        data_d       = data_q;
        count_d      = count_q;
        last_d       = last_q;

        if (rd) begin
            if (cnt_q == LAST_LANE) begin
                valid_d = 1'b1;
                data_d  = acc_ins;
                count_d = CW'(NW);
                last_d  = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_ins;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (i_flush && !flush_pend_q) flush_pend_d = 1'b1;

        // Pops are blocked while pending, so acc/cnt are stable here.
        if (flush_pend_q) begin
            if (cnt_q == '0) begin
                flush_pend_d = 1'b0;
            end else if (out_free) begin
                valid_d      = 1'b1;
                data_d       = acc_q;
                count_d      = {1'b0, cnt_q};
                last_d       = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            count_q      <= '0;
            last_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            count_q      <= count_d;
            last_q       <= last_d;
        end
    end

    assign o_rd    = rd;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_count = count_q;
    assign o_last  = last_q;
    assign o_busy  = (cnt_q != '0) || flush_pend_q;

endmodule
